// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
//
// Iterative multiply/divide unit for the multi-cycle CPU. It takes the two
// register-file read operands and computes MIPS MULTU/MULT/DIVU/DIV using one
// radix-2 step per clock. The 64-bit HI/LO result goes to the HI/LO write-back
// logic through a valid/ready handshake. Only one operation is in flight at a
// time.
//
// Sequence (edge 0 = acceptance edge):
//   IDLE (accept) -> CALC (edges 1..32, one step each) -> FIX (edge 33,
//   sign fixup, load hi/lo) -> DONE (out_valid, held until out_ready).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   operation request
//   in_ready   unit can accept a request (state == IDLE)
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a      rs operand: multiplicand / dividend
//   src_b      rt operand: multiplier / divisor
//   out_valid  result available (state == DONE)
//   out_ready  consumer takes the result
//   hi         MUL: upper product half, DIV: remainder
//   lo         MUL: lower product half, DIV: quotient
//   busy       state != IDLE
// -----------------------------------------------------------------------------
module mdu_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_d;
  logic [CW-1:0] cnt;

  // Operation context captured at acceptance.
  logic         is_div;
  logic         sign_a;
  logic         sign_b;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  // Multiply: acc is the shift-add accumulator {partial product, multiplier}.
  // Divide:   acc[W-1:0] shifts the dividend out and the quotient in;
  //           rem is the partial remainder (one bit wider than the divisor).
  logic [2*W-1:0] acc;
  logic [W:0]     rem;

  // Combinational step / fixup results.
  logic [2*W-1:0] acc_step;
  logic [W:0]     rem_step;
  logic [W-1:0]   hi_fix;
  logic [W-1:0]   lo_fix;

  // Acceptance-time sign/magnitude split.
  logic         acc_sign_a;
  logic         acc_sign_b;
  logic [W-1:0] acc_mag_a;
  logic [W-1:0] acc_mag_b;

  assign acc_sign_a = op[0] & src_a[W-1];
  assign acc_sign_b = op[0] & src_b[W-1];
  assign acc_mag_a  = acc_sign_a ? -src_a : src_a;
  assign acc_mag_b  = acc_sign_b ? -src_b : src_b;

  // ---------------------------------------------------------------------------
  // Control state, step counter and result registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create ordering races.
      state <= state_d;
      case (state)
        IDLE: if (in_valid) cnt <= '0;
        CALC: cnt <= cnt + 1'b1;
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.
  // NOTE: these carry no reset on purpose; they are always loaded at
  // acceptance before being used, and an aborted operation never reaches
  // hi/lo because the control registers above are reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      is_div <= op[1];
      sign_a <= acc_sign_a;
      sign_b <= acc_sign_b;
      mag_a  <= acc_mag_a;
      mag_b  <= acc_mag_b;
      // Multiply starts with the multiplier in the low half; divide starts
      // with the dividend there and an empty partial remainder.
      acc    <= op[1] ? {{W{1'b0}}, acc_mag_a} : {{W{1'b0}}, acc_mag_b};
      rem    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_step;
      rem    <= rem_step;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CALC;
      end
      CALC: if (cnt == LAST_STEP) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step, and the final sign fixup.
  // ---------------------------------------------------------------------------
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W+1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] mul_fixed;
  logic [W-1:0]   quo_fixed;
  logic [W-1:0]   rem_fixed;
  logic           neg_result;

  always_comb begin
    // Multiply: conditionally add the multiplicand to the upper half, then
    // shift the whole accumulator right with the carry.
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});

    // Restoring divide: bring down the next dividend bit, try the subtract,
    // keep it only when it does not go negative.
    div_shift = {rem[W-1:0], acc[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    div_ge    = ~div_diff[W+1];

    acc_step  = acc;
    rem_step  = rem;
    if (is_div) begin
      acc_step[W-1:0] = {acc[W-2:0], div_ge};
      rem_step        = div_ge ? div_diff[W:0] : div_shift;
    end else begin
      acc_step        = {mul_sum, acc[W-1:1]};
    end

    neg_result = sign_a ^ sign_b;
    mul_fixed  = neg_result ? -acc : acc;
    quo_fixed  = neg_result ? -acc[W-1:0] : acc[W-1:0];
    rem_fixed  = sign_a ? -rem[W-1:0] : rem[W-1:0];

    hi_fix = mul_fixed[2*W-1:W];
    lo_fix = mul_fixed[W-1:0];
    if (is_div) begin
      if (mag_b == '0) begin
        // Divide by zero: all-ones quotient, remainder is the original
        // dividend (re-signed from its magnitude).
        hi_fix = sign_a ? -mag_a : mag_a;
        lo_fix = '1;
      end else begin
        hi_fix = rem_fixed;
        lo_fix = quo_fixed;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
//
// Self-checking bench for mdu_iterative. Expected HI/LO values are pushed to a
// scoreboard queue when an operation is issued and popped when the unit
// presents its result. Directed cases come first, followed by a few random
// operations checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  always #5 clk = ~clk;

  mdu_iterative #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0]        res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_MULT:  res = sa * sb;
      OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic push(input string tag, input logic [63:0] expected);
    exp_q.push_back(expected);
    tag_q.push_back(tag);
  endtask

  // Present one request and hold it until the acceptance edge; returns #1
  // after that edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before issue", {63'd0, in_ready}, 64'd1);
    op       = o;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid. lat is the edge number (acceptance = 0) at
  // which a consumer first samples out_valid high.
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid within budget", {63'd0, out_valid}, 64'd1);
    lat = n + 1;
  endtask

  task automatic check_result();
    logic [63:0] e;
    string       t;
    check("scoreboard not empty", {63'd0, exp_q.size() != 0}, 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {hi, lo}, e);
      last_exp = e;
    end
    check("in_ready low in DONE", {63'd0, in_ready}, 64'd0);
  endtask

  // With out_ready high the result is handed off on the next edge and the
  // unit is ready again right after it.
  task automatic handoff();
    @(posedge clk);
    #1;
    check("in_ready after handoff", {63'd0, in_ready}, 64'd1);
    check("out_valid after handoff", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expected);
    int lat;
    push(tag, expected);
    issue(o, a, b);
    wait_valid(lat);
    check_result();
    handoff();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = OP_MULTU;
    src_a     = '0;
    src_b     = '0;

    // Reset state, observed before any clock edge.
    #1;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;

    // MULTU all-ones squared, with exact latency.
    push("MULTU ffffffff*ffffffff", 64'hFFFF_FFFE_0000_0001);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("busy after accept", {63'd0, busy}, 64'd1);
    wait_valid(lat);
    check("accept-to-valid cycles", 64'(lat), 64'd34);
    check_result();
    handoff();

    run_op("MULT -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);

    // Abort at CALC cycle 15: outputs drop without a clock edge.
    issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
    repeat (15) @(posedge clk);
    #2;
    check("busy before abort", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    run_op("MULTU 3*4 after reset", OP_MULTU, 32'd3, 32'd4, 64'd12);

    run_op("MULT 80000000*80000000", OP_MULT, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op("DIV -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_op("DIV 80000000/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000});
    run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});

    // Backpressure: result held for 10 cycles while a second request waits.
    out_ready = 1'b0;
    push("DIVU 1000/3 held", {32'd1, 32'd333});
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_valid(lat);
    check_result();
    op       = OP_MULTU;
    src_a    = 32'h0001_0000;
    src_b    = 32'h0001_0003;
    in_valid = 1'b1;
    push("MULTU queued behind backpressure", 64'h0000_0001_0003_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp out_valid", {63'd0, out_valid}, 64'd1);
      check("bp in_ready", {63'd0, in_ready}, 64'd0);
      check("bp hi/lo stable", {hi, lo}, last_exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release in_ready", {63'd0, in_ready}, 64'd1);
    check("bp release busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("queued request accepted", {63'd0, busy}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("hi/lo held during CALC", {hi, lo}, last_exp);
    wait_valid(lat);
    check_result();
    handoff();

    // Random operations against the behavioural model.
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op("random op", ro, ra, rb, model(ro, ra, rb));
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative multiply/divide unit sitting directly downstream of the register file in the multi-cycle CPU. It consumes the two register read operands, performs MIPS MULT/MULTU/DIV/DIVU in a fixed 34-cycle sequence, and presents the 64-bit HI/LO result through a valid/ready handshake to the HI/LO write-back logic. One operation is in flight at a time.

## Interface
- `DATA_WIDTH`, 32: operand width. Also sets the iteration count. Only 32 is verified.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst`=0 resets immediately.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request; equals (state==IDLE).
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a`  in  32  rs operand (register read port 1); multiplicand or dividend.
- `src_b`  in  32  rt operand (register read port 2); multiplier or divisor.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `hi`  out  32  MUL: upper product half. DIV: remainder.
- `lo`  out  32  MUL: lower product half. DIV: quotient.
- `busy`  out  1  high whenever state!=IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `op`, the signs of `src_a` and `src_b`, and their magnitudes. Magnitudes are the absolute value for signed ops and the raw value for unsigned ops.
  - Clear the 6-bit counter and go to CALC.
  - Inputs are ignored after acceptance.
- **CALC**
  - One radix-2 step per cycle on the magnitudes.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract, 33-bit partial remainder.
  - After 32 steps (counter 0..31), go to FIX.
- **FIX**
  - One cycle of sign correction, then load `hi`/`lo` and go to DONE.
  - MULT: negate the 64-bit product (two's complement) if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - Divide by zero (`src_b`==0), for both DIVU and DIV: `lo`=32'hFFFFFFFF, `hi`=original `src_a`. This overrides the sign fixup.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- **DONE**
  - `out_valid`=1; `hi`/`lo` held stable.
  - On `out_ready`, go to IDLE.
  - A new request is never accepted in the same cycle as the result handoff. `in_ready` rises the cycle after.
- `hi`/`lo` keep their last value while in IDLE/CALC/FIX. They update only on FIX→DONE.
- All arithmetic is modulo 2^64 (MUL) or 2^32 (DIV). No exceptions are raised.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `hi`=0, `lo`=0, counter=0.
  - Applied asynchronously while `rst`=0.
- Latency:
  - Acceptance edge = edge 0.
  - CALC covers edges 1..32; FIX is edge 33.
  - `out_valid` is high from edge 34 onward, i.e. 34 cycles from accept to valid.
- Back-to-back throughput: minimum 35 cycles per operation when `out_ready` is held high.
- Backpressure: `out_valid`, `hi` and `lo` stay stable for any number of cycles while `out_ready`=0.
- Reset mid-operation (any state): abort immediately. Outputs return to reset values and no result is produced.
- `in_valid` asserted while busy: ignored. The requester must hold it until `in_ready`.
- `out_ready` asserted while not in DONE: ignored.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `out_ready`=1 → `out_valid` exactly 34 cycles after accept, with `hi`=0xFFFFFFFE, `lo`=0x00000001; `in_ready` returns the next cycle.
- MULT 0xFFFFFFFD (−3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- Corner cases:
  - DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
  - DIV 0xFFFFFFF9/0 → `lo`=0xFFFFFFFF, `hi`=0xFFFFFFF9.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `hi`/`lo` stable, `in_ready`=0, and a second `in_valid` is ignored. Release → the second request is accepted the following cycle.
- Drop `rst` to 0 at CALC cycle 15 → `busy`, `out_valid`, `hi` and `lo` go to 0 without waiting for a clock edge. After release, a fresh MULTU 3×4 gives `lo`=12, `hi`=0.
